aes128_enc_iter: RTL and testbench

Iterative AES-128 encryption core: one round per clock with on-the-fly forward key expansion. It is the encrypt-direction counterpart of the decryptor's inverse round datapath. It reuses the same 128-bit state and byte ordering, so its ciphertext feeds the decryptor directly. It is a start/done block with a busy flag, intended to sit behind a bus or stream adapter.

---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/aes_enc_round.sv | 54 +++++
 rtl/aes128_enc_iter.sv | 100 ++++++++++
 tb/tb_aes128_enc_iter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte/word helpers for the encrypt core
// and the matching decryptor.
package aes_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Forward S-box, byte 0x00 at the most significant end.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      // Byte b occupies bits {~b,3'b111} down to {~b,3'b000}.
      return SBOX_TABLE[{~b, 3'b111} -: 8];
   endfunction

   // Round constant for key-expansion step 1..10; zero outside that range.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows,
// MixColumns (bypassed on the last round) and AddRoundKey.
// Byte i of a 128-bit block sits at bits [127-8i -: 8]; byte i = 4*col + row.
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_rkey,
   input  logic         i_last,
   output logic [127:0] o_state
);

   logic [7:0] w_sb  [16];
   logic [7:0] w_sr  [16];
   logic [7:0] w_mc  [16];
   logic [7:0] w_out [16];

   genvar gi;
   generate
      // Sixteen parallel S-boxes.
      for (gi = 0; gi < 16; gi++) begin : g_sub
         assign w_sb[gi] = sbox(i_state[127-8*gi -: 8]);
      end

      // Row r rotates left by r: out[col,row] = in[(col+row)%4,row].
      for (gi = 0; gi < 16; gi++) begin : g_shift
         assign w_sr[gi] = w_sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
      end

      // Column mix with the circulant {02 03 01 01}.
      for (gi = 0; gi < 4; gi++) begin : g_mix
         logic [7:0] w_a0, w_a1, w_a2, w_a3;
         assign w_a0 = w_sr[4*gi+0];
         assign w_a1 = w_sr[4*gi+1];
         assign w_a2 = w_sr[4*gi+2];
         assign w_a3 = w_sr[4*gi+3];
         assign w_mc[4*gi+0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
         assign w_mc[4*gi+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
         assign w_mc[4*gi+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
         assign w_mc[4*gi+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
      end

      // Final round skips the column mix; every round adds its key.
      for (gi = 0; gi < 16; gi++) begin : g_ark
         assign w_out[gi] = (i_last ? w_sr[gi] : w_mc[gi]) ^ i_rkey[127-8*gi -: 8];
      end
   endgenerate

   assign o_state = {w_out[0],  w_out[1],  w_out[2],  w_out[3],
                     w_out[4],  w_out[5],  w_out[6],  w_out[7],
                     w_out[8],  w_out[9],  w_out[10], w_out[11],
                     w_out[12], w_out[13], w_out[14], w_out[15]};

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded
// on the fly alongside the datapath. Start/done handshake with busy flag.
module aes128_enc_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] plaintext,
   output logic         busy,
   output logic         done,
   output logic [127:0] ciphertext
);

   state_t       r_fsm;
   state_t       w_fsm_next;
   logic [3:0]   r_rnd;
   logic [127:0] r_state;
   logic [127:0] r_rk;
   logic [127:0] r_ct;
   logic         r_done;

   logic         w_last;
   logic [31:0]  w_temp;
   logic [31:0]  w_k0, w_k1, w_k2, w_k3;
   logic [127:0] w_nk;
   logic [127:0] w_round_out;

   assign w_last = (r_rnd == 4'd10);

   // Forward key step: derive round key rnd from round key rnd-1.
   assign w_temp = sub_word(rot_word(r_rk[31:0])) ^ {rcon(r_rnd), 24'h0};
   assign w_k0   = r_rk[127:96] ^ w_temp;
   assign w_k1   = r_rk[95:64]  ^ w_k0;
   assign w_k2   = r_rk[63:32]  ^ w_k1;
   assign w_k3   = r_rk[31:0]   ^ w_k2;
   assign w_nk   = {w_k0, w_k1, w_k2, w_k3};

   aes_enc_round u_round (
      .i_state (r_state),
      .i_rkey  (w_nk),
      .i_last  (w_last),
      .o_state (w_round_out)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   // Next state: leave IDLE on start, return after the tenth round.
   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         IDLE:    if (start)  w_fsm_next = RUN;
         RUN:     if (w_last) w_fsm_next = IDLE;
         default: w_fsm_next = IDLE;
      endcase
   end

   // Datapath: capture block on accept, advance one round per cycle in RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rnd   <= 4'd0;
         r_state <= '0;
         r_rk    <= '0;
         r_ct    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_fsm == IDLE) begin
            if (start) begin
               r_state <= plaintext ^ key;
               r_rk    <= key;
               r_rnd   <= 4'd1;
            end
         end else begin
            r_rk <= w_nk;
            if (w_last) begin
               r_ct   <= w_round_out;
               r_done <= 1'b1;
               r_rnd  <= 4'd0;
            end else begin
               r_state <= w_round_out;
               r_rnd   <= r_rnd + 4'd1;
            end
         end
      end
   end

   assign busy       = (r_fsm == RUN);
   assign done       = r_done;
   assign ciphertext = r_ct;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Self-checking bench for aes128_enc_iter: FIPS-197 vectors, start held high,
// mid-run reset, and random blocks against a byte-level software AES.
`timescale 1ns/1ps
module tb_aes128_enc_iter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] plaintext = '0;
   logic         busy;
   logic         done;
   logic [127:0] ciphertext;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes128_enc_iter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .key        (key),
      .plaintext  (plaintext),
      .busy       (busy),
      .done       (done),
      .ciphertext (ciphertext)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] sbox_ref [256];
   logic [7:0] inv_sbox_ref [256];
   logic [7:0] ks [176];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   // S-box from its definition: multiplicative inverse then affine map.
   function automatic void build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox_ref[x] = s;
         inv_sbox_ref[s] = 8'(x);
      end
   endfunction

   function automatic void expand_key(input logic [127:0] k);
      logic [7:0] tmp [4];
      logic [7:0] t0;
      logic [7:0] rc;
      for (int i = 0; i < 16; i++) ks[i] = k[127-8*i -: 8];
      rc = 8'h01;
      for (int w = 4; w < 44; w++) begin
         for (int j = 0; j < 4; j++) tmp[j] = ks[4*(w-1)+j];
         if (w % 4 == 0) begin
            t0     = tmp[0];
            tmp[0] = sbox_ref[tmp[1]] ^ rc;
            tmp[1] = sbox_ref[tmp[2]];
            tmp[2] = sbox_ref[tmp[3]];
            tmp[3] = sbox_ref[t0];
            rc     = gf_mul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) ks[4*w+j] = ks[4*(w-4)+j] ^ tmp[j];
      end
   endfunction

   function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] p);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] res;
      expand_key(k);
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ ks[i];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_ref[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[4*c+row] = s[4*((c+row)%4)+row];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r < 10) begin
               s[4*c]   = gf_mul(8'h02, a0) ^ gf_mul(8'h03, a1) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gf_mul(8'h02, a1) ^ gf_mul(8'h03, a2) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gf_mul(8'h02, a2) ^ gf_mul(8'h03, a3);
               s[4*c+3] = gf_mul(8'h03, a0) ^ a1 ^ a2 ^ gf_mul(8'h02, a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[16*r+i];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Inverse cipher, used to confirm the core's output decrypts back.
   function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] ct);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] res;
      expand_key(k);
      for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ ks[160+i];
      for (int r = 9; r >= 0; r--) begin
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[4*((c+row)%4)+row] = s[4*c+row];
         for (int i = 0; i < 16; i++) s[i] = inv_sbox_ref[t[i]] ^ ks[16*r+i];
         if (r > 0) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
               s[4*c+1] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
               s[4*c+2] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
               s[4*c+3] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
            end
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // One transaction from an idle core. Edge T0 accepts; done is expected
   // after edge T0+10 (cycle T0+11). r1 is the state after the first round.
   task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                            output logic [127:0] ct, output logic [127:0] r1,
                            output int edges);
      key = k;
      plaintext = p;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      key = ~k;
      plaintext = ~p;
      edges = -1;
      ct = '0;
      r1 = '0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (e == 1) r1 = dut.r_state;
         if (done) begin
            edges = e;
            ct = ciphertext;
            check_eq("busy_at_done", 128'(busy), 128'd0);
            break;
         end
         if (e <= 9) check_eq("busy_run", 128'(busy), 128'd1);
      end
      $display("blk key=%h pt=%h ct=%h edges=%0d", k, p, ct, edges);
   endtask

   initial begin
      logic [127:0] ct, r1, k, p, exp_ct;
      logic [127:0] ct1, ct2;
      int edges, n_done, d1, d2;

      build_sbox();

      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 128'(busy), 128'd0);
      check_eq("rst_done", 128'(done), 128'd0);
      check_eq("rst_ct", ciphertext, 128'd0);
      check_eq("rst_state", dut.r_state, 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Known-answer vectors.
      run_block(C1_KEY, C1_PT, ct, r1, edges);
      check_eq("c1_ct", ct, C1_CT);
      check_eq("c1_lat", 128'(edges), 128'd10);
      run_block(B_KEY, B_PT, ct, r1, edges);
      check_eq("b_ct", ct, B_CT);
      check_eq("b_round1", r1, B_R1);
      check_eq("b_lat", 128'(edges), 128'd10);
      run_block(128'd0, 128'd0, ct, r1, edges);
      check_eq("zero_ct", ct, Z_CT);
      check_eq("hold_ct", ciphertext, Z_CT);

      // Start held for 30 edges; inputs switch to App. B while busy.
      key = C1_KEY;
      plaintext = C1_PT;
      start = 1'b1;
      @(posedge clk); #1;
      n_done = 0; d1 = -1; d2 = -1; ct1 = '0; ct2 = '0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (e == 3) begin
            key = B_KEY;
            plaintext = B_PT;
         end
         if (e == 29) start = 1'b0;
         if (done && e <= 30) begin
            n_done++;
            if (n_done == 1) begin d1 = e; ct1 = ciphertext; end
            if (n_done == 2) begin d2 = e; ct2 = ciphertext; end
         end
      end
      check_eq("held_ndone", 128'(n_done), 128'd2);
      check_eq("held_d1", 128'(d1), 128'd10);
      check_eq("held_d2", 128'(d2), 128'd21);
      check_eq("held_ct1", ct1, C1_CT);
      check_eq("held_ct2", ct2, B_CT);
      check_eq("held_idle", 128'(busy), 128'd0);
      $display("blk held-start dones=%0d at %0d,%0d ct1=%h ct2=%h", n_done, d1, d2, ct1, ct2);

      // Reset in the middle of a run.
      key = C1_KEY;
      plaintext = C1_PT;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_eq("mrst_busy", 128'(busy), 128'd0);
      check_eq("mrst_done", 128'(done), 128'd0);
      check_eq("mrst_ct", ciphertext, 128'd0);
      rst_n = 1'b1;
      n_done = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check_eq("mrst_nodone", 128'(n_done), 128'd0);
      check_eq("mrst_idle", 128'(busy), 128'd0);
      $display("blk mid-run reset, dones afterwards=%0d", n_done);
      run_block(C1_KEY, C1_PT, ct, r1, edges);
      check_eq("mrst_c1_ct", ct, C1_CT);

      // Random blocks with random idle gaps, checked against the model
      // and round-tripped through the inverse cipher.
      for (int n = 0; n < 1000; n++) begin
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         p = {$urandom(), $urandom(), $urandom(), $urandom()};
         exp_ct = model_encrypt(k, p);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         run_block(k, p, ct, r1, edges);
         check_eq("rnd_ct", ct, exp_ct);
         check_eq("rnd_lat", 128'(edges), 128'd10);
         check_eq("rnd_roundtrip", model_decrypt(k, ct), p);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
